psum_rbuffer: RTL

Read-side partial-sum buffer for the accumulation path. It prefetches up to four 64-bit rows of previously stored partial sums from output memory. It then serves them in order to the OutputStage, which adds each new tile row to its prefetched partial sum. It is the reader counterpart of the write buffer that stores accumulated rows back to the same output memory, and it uses the same 16-entry, 4-bit-address, 64-bit-data memory port.

---
 rtl/psum_rbuffer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/psum_rbuffer.sv
// psum_rbuffer: read-side partial-sum buffer; prefetches up to four 64-bit rows from output memory
// and serves them in order. Optional macro PSUM_RBUFFER_ADDR_CHECK_EN adds per-row destination checking.
module psum_rbuffer (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CLR_DP,
    input  logic        FETCH_REQ,
    input  logic [2:0]  ROW_TOTAL,
    input  logic [3:0]  BASE_ADDR,
    output logic        EN_rb,
    output logic [3:0]  RADDR_rb,
    input  logic [63:0] RDATA,
    input  logic        POP,
    input  logic [3:0]  ODST_rq,
    output logic [63:0] PSUM,
    output logic        PSUM_VALID,
    output logic        FETCH_DONE,
    output logic        DRAIN_DONE,
    output logic        BUSY,
    output logic        ADDR_ERR
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, READY} state_t;

    state_t      state;
    logic [2:0]  n_rows;
    logic [3:0]  base;
    logic [2:0]  issue_cnt;
    logic [2:0]  cap_cnt;
    logic [2:0]  pop_cnt;
    logic        rd_vld;
    logic [63:0] bank [4];

    logic [2:0]  n_req;
    logic        pop_fire;
    logic        last_pop;

    // Row counts of 0 or above 4 fall back to a full four-row fetch.
    assign n_req    = (ROW_TOTAL == 3'd0 || ROW_TOTAL > 3'd4) ? 3'd4 : ROW_TOTAL;
    assign pop_fire = (state == READY) && POP && !CLR_DP;
    assign last_pop = (pop_cnt == (n_rows - 3'd1));
    assign BUSY     = (state != IDLE);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            n_rows     <= '0;
            base       <= '0;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            pop_cnt    <= '0;
            rd_vld     <= 1'b0;
            EN_rb      <= 1'b0;
            RADDR_rb   <= '0;
            PSUM       <= '0;
            PSUM_VALID <= 1'b0;
            FETCH_DONE <= 1'b0;
            DRAIN_DONE <= 1'b0;
            // NOTE: the bank is small and must not leak rows across an abort, so it is reset like any flop.
            for (int i = 0; i < 4; i++) bank[i] <= '0;
        end else if (CLR_DP) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            pop_cnt    <= '0;
            rd_vld     <= 1'b0;
            EN_rb      <= 1'b0;
            RADDR_rb   <= '0;
            PSUM       <= '0;
            PSUM_VALID <= 1'b0;
            FETCH_DONE <= 1'b0;
            DRAIN_DONE <= 1'b0;
            for (int i = 0; i < 4; i++) bank[i] <= '0;
        end else begin
            PSUM_VALID <= 1'b0;
            FETCH_DONE <= 1'b0;
            DRAIN_DONE <= 1'b0;
            // Read data returns one cycle after its enable.
            rd_vld     <= EN_rb;
            if (rd_vld) begin
                bank[cap_cnt[1:0]] <= RDATA;
                cap_cnt            <= cap_cnt + 3'd1;
            end

            case (state)
                IDLE: begin
                    if (FETCH_REQ) begin
                        n_rows    <= n_req;
                        base      <= BASE_ADDR;
                        cap_cnt   <= '0;
                        pop_cnt   <= '0;
                        // The first read issues on the accepting edge so EN_rb is high from cycle 1.
                        issue_cnt <= 3'd1;
                        EN_rb     <= 1'b1;
                        RADDR_rb  <= BASE_ADDR;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue_cnt == n_rows) begin
                        EN_rb <= 1'b0;
                        state <= WAIT;
                    end else begin
                        RADDR_rb  <= base + {1'b0, issue_cnt};
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                end
                WAIT: begin
                    if (rd_vld && cap_cnt == (n_rows - 3'd1)) begin
                        FETCH_DONE <= 1'b1;
                        state      <= READY;
                    end
                end
                READY: begin
                    if (pop_fire) begin
                        PSUM       <= bank[pop_cnt[1:0]];
                        PSUM_VALID <= 1'b1;
                        pop_cnt    <= pop_cnt + 3'd1;
                        if (last_pop) begin
                            DRAIN_DONE <= 1'b1;
                            state      <= IDLE;
                            for (int i = 0; i < 4; i++) bank[i] <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PSUM_RBUFFER_ADDR_CHECK_EN
    logic [3:0] addr_bank [4];
    logic [3:0] rd_addr;
    logic       addr_err;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_addr  <= '0;
            addr_err <= 1'b0;
            for (int i = 0; i < 4; i++) addr_bank[i] <= '0;
        end else if (CLR_DP) begin
            rd_addr  <= '0;
            addr_err <= 1'b0;
            for (int i = 0; i < 4; i++) addr_bank[i] <= '0;
        end else begin
            // The address travels alongside its read so it lands in the same slot as the data.
            rd_addr <= RADDR_rb;
            if (rd_vld) addr_bank[cap_cnt[1:0]] <= rd_addr;
            if (pop_fire && ODST_rq != addr_bank[pop_cnt[1:0]]) addr_err <= 1'b1;
            if (pop_fire && last_pop) begin
                for (int i = 0; i < 4; i++) addr_bank[i] <= '0;
            end
        end
    end

    assign ADDR_ERR = addr_err;
`else
    logic unused_odst;
    assign unused_odst = ^ODST_rq;
    assign ADDR_ERR    = 1'b0;
`endif

endmodule
